// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial front end for the sequence-detector Moore machine.
//   A WIDTH-bit word is taken through a valid/ready handshake and sent one bit
//   per clk on ser_out. Each frame is marked with ser_valid, frame_start and
//   frame_done so downstream logic can line detector output up with frames.
//
//   Optional feature macro: SERIALIZER_PARITY_EN
//     When defined, one even-parity bit (XOR of all din bits) follows the data
//     bits, and frame_done moves to that bit-time.
//
// Parameters
//   WIDTH      bits per word, 2..32
//   MSB_FIRST  1: din[WIDTH-1] sent first, 0: din[0] sent first
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   din          in   parallel word
//   din_valid    in   din holds a word
//   din_ready    out  a word can be accepted this cycle
//   ser_out      out  serial bit (registered)
//   ser_valid    out  ser_out carries a frame bit (registered)
//   frame_start  out  first bit-time of a frame (registered)
//   frame_done   out  last bit-time of a frame (registered)
//   dbg_state    out  current FSM state encoding
//
// Handshake: a word transfers at the rising clk edge where din_valid and
// din_ready are both 1. din_ready never depends on din_valid. din_ready is 1
// in IDLE and in the final bit-time of a frame, so a word offered during the
// final bit-time starts a new frame with no gap in ser_valid.
// -----------------------------------------------------------------------------
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic [WIDTH-1:0] shreg_q, shreg_nx;
  logic             accept;
  logic             data_end;
  logic             last_bit;
  logic             cur_bit;
  logic             ser_out_nx, ser_valid_nx, frame_start_nx, frame_done_nx;
`ifdef SERIALIZER_PARITY_EN
  logic             par_q, par_nx;
`endif

  always_comb begin
    data_end = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`ifdef SERIALIZER_PARITY_EN
    last_bit = (state_q == PARITY);
`else
    last_bit = data_end;
`endif
    din_ready = !rst && ((state_q == IDLE) || last_bit);
    accept    = din_valid && din_ready;

    state_nx = state_q;
    cnt_nx   = cnt_q;
    shreg_nx = shreg_q;
`ifdef SERIALIZER_PARITY_EN
    par_nx   = par_q;
`endif

    if (accept) begin
      // New frame: accepted from IDLE or from the final bit-time alike.
      state_nx = SHIFT;
      cnt_nx   = '0;
      shreg_nx = din;
`ifdef SERIALIZER_PARITY_EN
      par_nx   = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (!data_end) begin
            cnt_nx = cnt_q + 1'b1;
            // The bit to send always sits at the outgoing end of shreg.
            if (MSB_FIRST) shreg_nx = {shreg_q[WIDTH-2:0], 1'b0};
            else           shreg_nx = {1'b0, shreg_q[WIDTH-1:1]};
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = IDLE;
            cnt_nx   = '0;
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
`endif
        default: ;
      endcase
    end

    // Serial outputs are computed from next-state values and registered,
    // so they line up with the state they describe.
    cur_bit        = MSB_FIRST ? shreg_nx[WIDTH-1] : shreg_nx[0];
    ser_valid_nx   = (state_nx != IDLE);
    frame_start_nx = (state_nx == SHIFT) && (cnt_nx == '0);
`ifdef SERIALIZER_PARITY_EN
    frame_done_nx  = (state_nx == PARITY);
    ser_out_nx     = (state_nx == PARITY) ? par_nx
                   : ((state_nx == SHIFT) && cur_bit);
`else
    frame_done_nx  = (state_nx == SHIFT) && (cnt_nx == LAST_CNT);
    ser_out_nx     = (state_nx == SHIFT) && cur_bit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_nx;
      cnt_q       <= cnt_nx;
      shreg_q     <= shreg_nx;
      ser_out     <= ser_out_nx;
      ser_valid   <= ser_valid_nx;
      frame_start <= frame_start_nx;
      frame_done  <= frame_done_nx;
`ifdef SERIALIZER_PARITY_EN
      par_q       <= par_nx;
`endif
    end
  end

  assign dbg_state = state_q;

endmodule
